fetch_queue: RTL and testbench

Instruction-fetch stage of the `mips` core. It owns the fetch PC register and presents that PC to the instruction memory. It captures each returned instruction, together with its PC+4, into a small FIFO feeding the decode stage. It also handles decode-stage redirects (branch/jump) and optionally halts fetch at a program-end address.

---
 rtl/fetch_queue_if.sv | 24 ++
 rtl/fetch_queue.sv | 82 ++++++++
 tb/tb_fetch_queue.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for fetch_queue: Imem address/data, redirect,
// stall and the queue-head outputs. master = fetch_queue, slave = decode/Imem side.
interface fetch_queue_if;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic [31:0] InstrF;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic        StallD;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        Halted;

  modport master (
    output PCF, PCPlus4F, ValidD, InstrD, PCPlus4D, Halted,
    input  InstrF, PCSrcD, PCBranchD, StallD
  );

  modport slave (
    input  PCF, PCPlus4F, ValidD, InstrD, PCPlus4D, Halted,
    output InstrF, PCSrcD, PCBranchD, StallD
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC register plus a DEPTH-entry {instr, pc+4} FIFO to decode.
// Define FETCH_HALT_EN to stop fetching after the instruction at END_PC is enqueued.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] END_PC   = 32'h0000_007C
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master fq
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

`ifdef FETCH_HALT_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  logic [31:0]   pc_q;
  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc4   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          halted_q;
  logic          valid;
  logic          enq;
  logic          deq;

  assign valid = (count != '0);
  assign enq   = reset && !fq.PCSrcD && !halted_q && (count < CNT_DEPTH);
  assign deq   = valid && !fq.StallD && !fq.PCSrcD;

  assign fq.PCF      = pc_q;
  assign fq.PCPlus4F = pc_q + 32'd4;
  assign fq.ValidD   = valid;
  assign fq.InstrD   = valid ? mem_instr[rd_ptr] : 32'd0;
  assign fq.PCPlus4D = valid ? mem_pc4[rd_ptr]   : 32'd0;
  assign fq.Halted   = halted_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      halted_q <= 1'b0;
    end else if (fq.PCSrcD) begin
      pc_q     <= fq.PCBranchD;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      halted_q <= 1'b0;
    end else begin
      if (enq) begin
        pc_q   <= pc_q + 32'd4;
        wr_ptr <= wr_ptr + PTR_ONE;
        // The END_PC entry is still queued; only later fetches are blocked.
        if (HALT_EN && (pc_q == END_PC))
          halted_q <= 1'b1;
      end
      if (deq)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (enq && !deq)
        count <= count + CNT_ONE;
      else if (!enq && deq)
        count <= count - CNT_ONE;
    end
  end

  // Storage needs no reset: entries are only visible through a nonzero count.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_instr[wr_ptr] <= fq.InstrF;
      mem_pc4[wr_ptr]   <= fq.PCPlus4F;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random stimulus,
// checked every cycle against a queue-based behavioural model.
module tb_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] END_PC   = 32'h0000_007C;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  logic clk;
  logic reset;
  fetch_queue_if bus ();

  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .END_PC(END_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (bus)
  );

  function automatic logic [31:0] imem(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign bus.InstrF = imem(bus.PCF);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  logic [31:0] m_pc = RESET_PC;
  bit          m_halted = 1'b0;
  ent_t        m_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: plain FIFO semantics, decisions taken from sizes before the edge.
  task automatic model_edge(input bit r, input bit src, input logic [31:0] tgt, input bit stall);
    bit do_enq, do_deq;
    ent_t e;
    if (!r) begin
      m_pc = RESET_PC; m_q.delete(); m_halted = 1'b0;
    end else if (src) begin
      m_pc = tgt; m_q.delete(); m_halted = 1'b0;
    end else begin
      do_deq = (m_q.size() != 0) && !stall;
      do_enq = !m_halted && (m_q.size() < DEPTH);
      if (do_deq) void'(m_q.pop_front());
      if (do_enq) begin
        e.instr = imem(m_pc);
        e.pc4   = m_pc + 32'd4;
        m_q.push_back(e);
        if (HALT_EN && m_pc == END_PC) m_halted = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input bit r, input bit src, input logic [31:0] tgt, input bit stall);
    reset         = r;
    bus.PCSrcD    = src;
    bus.PCBranchD = tgt;
    bus.StallD    = stall;
    @(posedge clk);
    #1;
    model_edge(r, src, tgt, stall);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("PCF", bus.PCF, m_pc);
      chk("PCPlus4F", bus.PCPlus4F, m_pc + 32'd4);
      chk("ValidD", {31'd0, bus.ValidD}, {31'd0, m_q.size() != 0});
      chk("InstrD", bus.InstrD, (m_q.size() != 0) ? m_q[0].instr : 32'd0);
      chk("PCPlus4D", bus.PCPlus4D, (m_q.size() != 0) ? m_q[0].pc4 : 32'd0);
      chk("Halted", {31'd0, bus.Halted}, {31'd0, m_halted});
    end
  end

  initial begin
    logic [31:0] tgt;
    reset = 1'b0; bus.PCSrcD = 1'b0; bus.PCBranchD = '0; bus.StallD = 1'b0;

    // Reset held low three cycles, then release with StallD=0.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0);
    chk_en = 1'b1;
    @(negedge clk); #1;
    chk("rst_pcf", bus.PCF, 32'h0);
    chk("rst_valid", {31'd0, bus.ValidD}, 32'd0);
    chk("rst_instr", bus.InstrD, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk); #1;
    chk("w0_instr", bus.InstrD, 32'h1000_0000);
    chk("w0_pc4", bus.PCPlus4D, 32'd4);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk); #1;
    chk("w1_instr", bus.InstrD, 32'h1000_0001);
    chk("w1_pc4", bus.PCPlus4D, 32'd8);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk); #1;
    chk("w2_instr", bus.InstrD, 32'h1000_0002);

    // Stall until full: PCF freezes; drain resumes fetch one cycle after the first deq.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk); #1;
    chk("full_pcf", bus.PCF, 32'h18);
    chk("full_head", bus.InstrD, 32'h1000_0002);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    @(negedge clk); #1;
    chk("frozen_pcf", bus.PCF, 32'h18);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk); #1;
    chk("drain1_instr", bus.InstrD, 32'h1000_0003);
    chk("drain1_pcf", bus.PCF, 32'h18);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk); #1;
    chk("drain2_instr", bus.InstrD, 32'h1000_0004);
    chk("resume_pcf", bus.PCF, 32'h1C);

    // Redirect with 3 entries queued.
    step(1'b1, 1'b1, 32'h40, 1'b0);
    @(negedge clk); #1;
    chk("redir_valid", {31'd0, bus.ValidD}, 32'd0);
    chk("redir_pcf", bus.PCF, 32'h40);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk); #1;
    chk("redir_instr", bus.InstrD, 32'h1000_0010);
    chk("redir_pc4", bus.PCPlus4D, 32'h44);

    // Reset while full and stalled.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    @(negedge clk); #1;
    chk("mid_rst_valid", {31'd0, bus.ValidD}, 32'd0);
    chk("mid_rst_instr", bus.InstrD, 32'd0);
    chk("mid_rst_pcf", bus.PCF, RESET_PC);
    chk("mid_rst_halt", {31'd0, bus.Halted}, 32'd0);

    // Run across END_PC.
    step(1'b1, 1'b1, 32'h70, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk); #1;
`ifdef FETCH_HALT_EN
    chk("halt_set", {31'd0, bus.Halted}, 32'd1);
    chk("halt_pcf", bus.PCF, 32'h80);
    step(1'b1, 1'b1, 32'h0, 1'b0);
    @(negedge clk); #1;
    chk("halt_clr", {31'd0, bus.Halted}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 1'b0);
    @(negedge clk); #1;
    chk("restart_instr", bus.InstrD, 32'h1000_0000);
`else
    chk("no_halt", {31'd0, bus.Halted}, 32'd0);
    chk("no_halt_pcf", bus.PCF, 32'h90);
`endif

    // Random phase, including targets near the 32-bit wrap.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: tgt = 32'hFFFF_FFF0 + {28'd0, 2'b00, 2'($urandom_range(0, 3))} * 32'd4;
        default: tgt = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      endcase
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0), tgt,
           ($urandom_range(0, 1) == 1));
    end
    @(negedge clk); #1;
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
